// File: rtl/hist_ctrl_gen.sv
// Histogram sequencer: scans dim x dim pixels through LANES lane counters, then merges the
// per-lane counts of each bin into histogram memory (plain or cumulative).
module hist_ctrl_gen #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned BINS    = 8,
  parameter int unsigned DIM_W   = 7,
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned PADDR_W = 14,
  parameter int unsigned HADDR_W = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic [DIM_W-1:0]         dim,
  input  logic                     cum_mode,
  input  logic [LANES*CNT_W-1:0]   hist_in,
  output logic [PADDR_W-1:0]       addr_pix,
  output logic                     en_hist,
  output logic [LANES-1:0]         lane_mask,
  output logic                     clr_hist,
  output logic [HADDR_W-1:0]       addr_bin,
  output logic                     we_hist,
  output logic [HADDR_W-1:0]       addr_hist,
  output logic [DATA_W-1:0]        dataout_hist,
  output logic                     busy,
  output logic                     start
);

  localparam int unsigned LaneShift = $clog2(LANES);
  localparam int unsigned LaneW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SqW       = 2 * DIM_W + 1;
  localparam int unsigned WordsW    = PADDR_W + 1;

  typedef enum logic [2:0] {StIdle, StClear, StScan, StDrain, StRead, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [WordsW-1:0]   words_q, words_d;
  logic [LaneW-1:0]    rem_q, rem_d;
  logic                cum_q, cum_d;
  logic [PADDR_W-1:0]  k_q, k_d;
  logic [HADDR_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;

  logic [PADDR_W-1:0]  addr_pix_q, addr_pix_d;
  logic                en_q, en_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic                clr_q, clr_d;
  logic [HADDR_W-1:0]  addr_bin_q, addr_bin_d;
  logic                we_q, we_d;
  logic [HADDR_W-1:0]  addr_hist_q, addr_hist_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;

  logic [SqW-1:0]      sq, sq_up;
  logic [LANES-1:0]    tail_mask;
  logic [DATA_W-1:0]   sum;
  logic                last_bin;

  always_comb begin
    sq    = SqW'(dim) * SqW'(dim);
    sq_up = (sq + SqW'(LANES - 1)) >> LaneShift;
  end

  always_comb begin
    tail_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      tail_mask[i] = (rem_q == '0) || (LaneW'(i) < rem_q);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + DATA_W'(hist_in[i*CNT_W +: CNT_W]);
    end
  end

  assign last_bin = (b_q == HADDR_W'(BINS - 1));

  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    rem_d       = rem_q;
    cum_d       = cum_q;
    k_d         = k_q;
    b_d         = b_q;
    acc_d       = acc_q;
    addr_pix_d  = '0;
    en_d        = 1'b0;
    mask_d      = '0;
    clr_d       = 1'b0;
    addr_bin_d  = '0;
    we_d        = 1'b0;
    addr_hist_d = '0;
    data_d      = '0;
    start_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ready) begin
          state_d = StClear;
          words_d = WordsW'(sq_up);
          rem_d   = LaneW'(sq & SqW'(LANES - 1));
          cum_d   = cum_mode;
          acc_d   = '0;
          clr_d   = 1'b1;
        end
      end
      StClear: begin
        k_d = '0;
        // An empty image still spends one cycle in Drain (with en_hist low) so the
        // run length stays 1 + words + 1 + 2*BINS + 1 for every dim.
        if (words_q != '0) begin
          state_d = StScan;
          mask_d  = '1;
        end else begin
          state_d = StDrain;
        end
      end
      StScan: begin
        en_d = 1'b1;
        if (WordsW'(k_q) == words_q - WordsW'(1)) begin
          state_d = StDrain;
          mask_d  = tail_mask;
        end else begin
          k_d        = k_q + PADDR_W'(1);
          addr_pix_d = k_q + PADDR_W'(1);
          mask_d     = '1;
        end
      end
      StDrain: begin
        state_d = StRead;
        b_d     = '0;
      end
      StRead: begin
        state_d     = StWrite;
        we_d        = 1'b1;
        addr_hist_d = b_q;
        data_d      = cum_q ? (acc_q + sum) : sum;
        acc_d       = acc_q + sum;
        // Present the next bin early so its counts are valid during the next Read.
        addr_bin_d  = last_bin ? '0 : b_q + HADDR_W'(1);
      end
      StWrite: begin
        if (last_bin) begin
          state_d = StDone;
          start_d = 1'b1;
        end else begin
          state_d    = StRead;
          b_d        = b_q + HADDR_W'(1);
          addr_bin_d = b_q + HADDR_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      words_q     <= '0;
      rem_q       <= '0;
      cum_q       <= 1'b0;
      k_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      addr_pix_q  <= '0;
      en_q        <= 1'b0;
      mask_q      <= '0;
      clr_q       <= 1'b0;
      addr_bin_q  <= '0;
      we_q        <= 1'b0;
      addr_hist_q <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      words_q     <= words_d;
      rem_q       <= rem_d;
      cum_q       <= cum_d;
      k_q         <= k_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      addr_pix_q  <= addr_pix_d;
      en_q        <= en_d;
      mask_q      <= mask_d;
      clr_q       <= clr_d;
      addr_bin_q  <= addr_bin_d;
      we_q        <= we_d;
      addr_hist_q <= addr_hist_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
    end
  end

  assign addr_pix     = addr_pix_q;
  assign en_hist      = en_q;
  assign lane_mask    = mask_q;
  assign clr_hist     = clr_q;
  assign addr_bin     = addr_bin_q;
  assign we_hist      = we_q;
  assign addr_hist    = addr_hist_q;
  assign dataout_hist = data_q;
  assign busy         = busy_q;
  assign start        = start_q;

endmodule

// File: tb/tb_hist_ctrl_gen.sv
// Bench for hist_ctrl_gen: lane-counter bank model with 1-cycle read latency, per-run
// expectations derived from dim, cum_mode and the counts table.
module tb_hist_ctrl_gen;

  localparam int LANES   = 4;
  localparam int BINS    = 8;
  localparam int DIM_W   = 7;
  localparam int CNT_W   = 14;
  localparam int PADDR_W = 14;
  localparam int HADDR_W = 6;
  localparam int DATA_W  = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ready = 1'b0;
  logic [DIM_W-1:0]       dim = '0;
  logic                   cum_mode = 1'b0;
  logic [LANES*CNT_W-1:0] hist_in;
  logic [PADDR_W-1:0]     addr_pix;
  logic                   en_hist;
  logic [LANES-1:0]       lane_mask;
  logic                   clr_hist;
  logic [HADDR_W-1:0]     addr_bin;
  logic                   we_hist;
  logic [HADDR_W-1:0]     addr_hist;
  logic [DATA_W-1:0]      dataout_hist;
  logic                   busy;
  logic                   start;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int cnt [BINS][LANES];
  logic [HADDR_W-1:0] bin_lat;

  hist_ctrl_gen #(
    .LANES(LANES), .BINS(BINS), .DIM_W(DIM_W), .CNT_W(CNT_W),
    .PADDR_W(PADDR_W), .HADDR_W(HADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .dim          (dim),
    .cum_mode     (cum_mode),
    .hist_in      (hist_in),
    .addr_pix     (addr_pix),
    .en_hist      (en_hist),
    .lane_mask    (lane_mask),
    .clr_hist     (clr_hist),
    .addr_bin     (addr_bin),
    .we_hist      (we_hist),
    .addr_hist    (addr_hist),
    .dataout_hist (dataout_hist),
    .busy         (busy),
    .start        (start)
  );

  always #5 clk = ~clk;

  // Lane counter bank: counts for addr_bin appear one cycle later.
  always @(posedge clk or negedge rst) begin
    if (!rst) bin_lat <= '0;
    else      bin_lat <= addr_bin;
  end

  always_comb begin
    hist_in = '0;
    if (int'(bin_lat) < BINS) begin
      for (int l = 0; l < LANES; l++) hist_in[l*CNT_W +: CNT_W] = CNT_W'(cnt[int'(bin_lat)][l]);
    end
  end

  always @(negedge clk) if (start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int b = 0; b < BINS; b++)
      for (int l = 0; l < LANES; l++)
        cnt[b][l] = rnd ? int'($urandom_range(0, (1 << CNT_W) - 1)) : b + 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_pix"}, addr_pix, 0);
    check({tag, "_en_hist"}, en_hist, 0);
    check({tag, "_lane_mask"}, lane_mask, 0);
    check({tag, "_clr_hist"}, clr_hist, 0);
    check({tag, "_addr_bin"}, addr_bin, 0);
    check({tag, "_we_hist"}, we_hist, 0);
    check({tag, "_addr_hist"}, addr_hist, 0);
    check({tag, "_dataout"}, dataout_hist, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, start, 0);
  endtask

  // One run: accept on the next rising edge, then check every cycle up to the done pulse
  // and the IDLE cycle that follows it. Cycle n=1 is the cycle right after the accept edge.
  task automatic run(input int d, input bit c, input bit toggle, input bit keep);
    int words, rem, n_start, acc, s;
    bit exp_en;
    logic [LANES-1:0] exp_mask;
    logic [HADDR_W-1:0] wa[$];
    logic [DATA_W-1:0]  wd[$];
    words   = (d * d + LANES - 1) / LANES;
    rem     = (d * d) % LANES;
    n_start = (words > 0) ? words + 3 + 2 * BINS : 3 + 2 * BINS;
    dim      = DIM_W'(d);
    cum_mode = c;
    ready    = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) ready = 1'b0;
    for (int n = 1; n <= n_start; n++) begin
      @(negedge clk);
      exp_en = (words > 0) && (n >= 3) && (n <= words + 2);
      check("busy", busy, 1);
      check("clr_hist", clr_hist, n == 1);
      check("en_hist", en_hist, exp_en);
      if (exp_en) begin
        exp_mask = (n == words + 2 && rem != 0) ? LANES'((1 << rem) - 1) : {LANES{1'b1}};
        check("lane_mask", lane_mask, exp_mask);
      end
      if (words > 0 && n >= 2 && n <= words + 1) check("addr_pix", addr_pix, n - 2);
      check("start", start, n == n_start);
      if (we_hist) begin
        wa.push_back(addr_hist);
        wd.push_back(dataout_hist);
      end
      if (n == n_start) begin
        ready = keep;
      end else if (toggle) begin
        ready    = 1'($urandom_range(0, 1));
        dim      = DIM_W'($urandom);
        cum_mode = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_start", start, 0);
    check("idle_clr", clr_hist, 0);
    check("write_count", wa.size(), BINS);
    acc = 0;
    for (int b = 0; b < BINS; b++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) s += cnt[b][l];
      acc += s;
      if (b < wa.size()) begin
        check("addr_hist", wa[b], b);
        check("dataout_hist", wd[b], c ? acc : s);
      end
    end
  endtask

  initial begin
    int s0;
    bit found;
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    fill(1'b0);
    run(4, 1'b0, 1'b0, 1'b0);
    run(3, 1'b1, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0, 1'b0);
    run(0, 1'b1, 1'b0, 1'b0);

    // Abort mid-scan, then a clean rerun must give exactly one done pulse.
    s0       = start_cnt;
    dim      = DIM_W'(8);
    cum_mode = 1'b0;
    ready    = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (addr_pix == 2 && en_hist) found = 1'b1;
    end
    check("abort_reached", found, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort_idle");
    run(5, 1'b1, 1'b0, 1'b0);
    check("one_start", start_cnt - s0, 1);

    fill(1'b1);
    run(6, 1'b1, 1'b1, 1'b0);
    run(7, 1'b0, 1'b1, 1'b0);
    run(7, 1'b1, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0);
    run(127, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      fill(1'b1);
      run(int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
